// File: rtl/mul_share_arbiter.sv
// Two-requester front end for one shared external combinational multiplier:
// round-robin grant, registered operand stage S1 and registered result stage S2.
// Optional macro ARB_FIXED_PRIO_EN: requester 0 always wins a simultaneous request.
module mul_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               ReqValid0,
    input  logic [WIDTH-1:0]   ReqA0,
    input  logic [WIDTH-1:0]   ReqB0,
    output logic               ReqReady0,
    input  logic               ReqValid1,
    input  logic [WIDTH-1:0]   ReqA1,
    input  logic [WIDTH-1:0]   ReqB1,
    output logic               ReqReady1,
    output logic [WIDTH-1:0]   MulA,
    output logic [WIDTH-1:0]   MulB,
    input  logic [2*WIDTH-1:0] MulP,
    output logic               RspValid,
    output logic [2*WIDTH-1:0] RspProduct,
    output logic               RspId,
    input  logic               RspReady
);

    logic               w_s2_stall;
    logic               w_s2_adv;
    logic               w_accept;
    logic               w_grant;
    logic               w_handshake;

    logic               r_s1_valid;
    logic               r_s1_id;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_product;
`ifndef ARB_FIXED_PRIO_EN
    logic               r_last_grant;
`endif

    // Pipeline flow control and requester selection.
    always_comb begin
        w_s2_stall = r_rsp_valid && !RspReady;
        w_s2_adv   = r_s1_valid && !w_s2_stall;
        // Gating with Rst_n keeps both readies low while reset is held.
        w_accept   = Rst_n && (!r_s1_valid || w_s2_adv);
        if (ReqValid0 && ReqValid1) begin
`ifdef ARB_FIXED_PRIO_EN
            w_grant = 1'b0;
`else
            w_grant = !r_last_grant;
`endif
        end else begin
            w_grant = ReqValid1;
        end
        w_handshake = w_accept && (ReqValid0 || ReqValid1);
        ReqReady0   = w_handshake && !w_grant;
        ReqReady1   = w_handshake && w_grant;
    end

    // Operand stage S1: captures the granted operands, empties when S1 moves on.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            if (w_handshake) begin
                r_s1_valid   <= 1'b1;
                r_s1_id      <= w_grant;
                r_mul_a      <= w_grant ? ReqA1 : ReqA0;
                r_mul_b      <= w_grant ? ReqB1 : ReqB0;
`ifndef ARB_FIXED_PRIO_EN
                r_last_grant <= w_grant;
`endif
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Result stage S2: latches the product, holds it stable while stalled.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_product <= '0;
        end else begin
            if (w_s2_adv) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_id      <= r_s1_id;
                r_rsp_product <= MulP;
            end else if (!w_s2_stall) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign MulA       = r_mul_a;
    assign MulB       = r_mul_b;
    assign RspValid   = r_rsp_valid;
    assign RspId      = r_rsp_id;
    assign RspProduct = r_rsp_product;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: transaction-level scoreboard model
// checked every cycle, plus directed tests with hand-computed literal values.
module tb_mul_share_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ReqValid0, ReqValid1, ReqReady0, ReqReady1;
    logic [7:0]  ReqA0, ReqB0, ReqA1, ReqB1, MulA, MulB;
    logic [15:0] MulP, RspProduct;
    logic        RspValid, RspId, RspReady;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    mul_share_arbiter #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid0(ReqValid0), .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqReady0(ReqReady0),
        .ReqValid1(ReqValid1), .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqReady1(ReqReady1),
        .MulA(MulA), .MulB(MulB), .MulP(MulP),
        .RspValid(RspValid), .RspProduct(RspProduct), .RspId(RspId), .RspReady(RspReady)
    );

    // The shared multiplier itself lives outside the arbiter.
    assign MulP = {8'd0, MulA} * {8'd0, MulB};

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: queue of accepted ops in order, each tagged with its handshake edge.
    typedef struct {
        logic [15:0] p;
        logic        id;
        int          e;
    } exp_t;

    exp_t q[$];
    logic m_last;
    logic m_acc, m_g, m_r0, m_r1, m_rv;
    exp_t m_new;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("rst_ready0", {31'd0, ReqReady0}, 32'd0);
            check("rst_ready1", {31'd0, ReqReady1}, 32'd0);
            check("rst_rspvalid", {31'd0, RspValid}, 32'd0);
            q.delete();
            m_last = 1'b1;
        end else begin
            // Only full when two ops are outstanding and the consumer refuses.
            m_acc = !(q.size() >= 2 && !RspReady);
            if (ReqValid0 && ReqValid1) begin
`ifdef ARB_FIXED_PRIO_EN
                m_g = 1'b0;
`else
                m_g = !m_last;
`endif
            end else begin
                m_g = ReqValid1;
            end
            m_r0 = m_acc && ReqValid0 && !m_g;
            m_r1 = m_acc && ReqValid1 && m_g;
            m_rv = (q.size() > 0) && (q[0].e < cyc);
            check("ready0", {31'd0, ReqReady0}, {31'd0, m_r0});
            check("ready1", {31'd0, ReqReady1}, {31'd0, m_r1});
            check("rspvalid", {31'd0, RspValid}, {31'd0, m_rv});
            if (m_rv) begin
                check("rspproduct", {16'd0, RspProduct}, {16'd0, q[0].p});
                check("rspid", {31'd0, RspId}, {31'd0, q[0].id});
                if (RspReady) void'(q.pop_front());
            end
            if (m_r0 || m_r1) begin
                m_new.id = m_g;
                m_new.p  = m_g ? ({8'd0, ReqA1} * {8'd0, ReqB1}) : ({8'd0, ReqA0} * {8'd0, ReqB0});
                m_new.e  = cyc + 1;
                q.push_back(m_new);
                m_last = m_g;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        ReqValid0 = 1'b0;
        ReqValid1 = 1'b0;
        RspReady  = 1'b1;
        repeat (2) step();
        Rst_n = 1'b1;
    endtask

    // Issue one op from requester id and wait (bounded) for its product.
    task automatic single_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp, input string name);
        int k;
        if (id) begin ReqValid1 = 1'b1; ReqA1 = a; ReqB1 = b; end
        else    begin ReqValid0 = 1'b1; ReqA0 = a; ReqB0 = b; end
        k = 0;
        @(negedge Clk);
        while (!(id ? ReqReady1 : ReqReady0) && k < 20) begin k++; @(negedge Clk); end
        step();
        ReqValid0 = 1'b0;
        ReqValid1 = 1'b0;
        k = 0;
        @(negedge Clk);
        while (!RspValid && k < 20) begin k++; @(negedge Clk); end
        check(name, {16'd0, RspProduct}, {16'd0, exp});
        step();
    endtask

    logic g[6];
    logic [15:0] held;
    int acc;

    initial begin
        ReqA0 = 8'd0; ReqB0 = 8'd0; ReqA1 = 8'd0; ReqB1 = 8'd0;
        do_reset();
        check("rst_mula", {24'd0, MulA}, 32'd0);
        check("rst_rspproduct", {16'd0, RspProduct}, 32'd0);

        // Test 1: single op, exact latency.
        ReqValid0 = 1'b1; ReqA0 = 8'd13; ReqB0 = 8'd11;
        @(negedge Clk);
        check("t1_ready0", {31'd0, ReqReady0}, 32'd1);
        step();
        ReqValid0 = 1'b0;
        check("t1_rv_early", {31'd0, RspValid}, 32'd0);
        check("t1_mula", {24'd0, MulA}, 32'd13);
        step();
        check("t1_rv", {31'd0, RspValid}, 32'd1);
        check("t1_prod", {16'd0, RspProduct}, 32'd143);
        check("t1_id", {31'd0, RspId}, 32'd0);
        repeat (2) step();

        // Test 2: both valid every cycle, alternating grants from reset.
        do_reset();
        ReqValid0 = 1'b1; ReqValid1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ReqA0 = 8'(10 + i); ReqB0 = 8'(3 + i);
            ReqA1 = 8'(20 + i); ReqB1 = 8'(7 + i);
            @(negedge Clk);
            g[i] = ReqReady1;
            step();
        end
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        for (int i = 0; i < 6; i++) check("t2_grant", {31'd0, g[i]}, 32'(i % 2));
        repeat (3) step();

        // Test 3: backpressure with three ops offered.
        RspReady = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 8'd3; ReqB0 = 8'd4;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (ReqReady0) acc++;
            step();
            if (acc == 1) begin ReqA0 = 8'd5; ReqB0 = 8'd6; end
            else if (acc == 2) begin ReqA0 = 8'd7; ReqB0 = 8'd8; end
        end
        check("t3_accepted", 32'(acc), 32'd2);
        @(negedge Clk);
        check("t3_full_r0", {31'd0, ReqReady0}, 32'd0);
        check("t3_full_r1", {31'd0, ReqReady1}, 32'd0);
        held = RspProduct;
        check("t3_held", {16'd0, held}, 32'd12);
        repeat (2) step();
        check("t3_stable", {16'd0, RspProduct}, {16'd0, held});
        RspReady = 1'b1;
        @(negedge Clk);
        check("t3_release_r0", {31'd0, ReqReady0}, 32'd1);
        step();
        ReqValid0 = 1'b0;
        repeat (4) step();

        // Test 4: operand boundaries.
        single_op(1'b1, 8'hFF, 8'hFF, 16'hFE01, "t4_ffff");
        single_op(1'b0, 8'h00, 8'hFF, 16'h0000, "t4_zero");
        repeat (2) step();

        // Test 5: reset with S1 and S2 full.
        RspReady = 1'b0;
        ReqValid0 = 1'b1; ReqA0 = 8'd2; ReqB0 = 8'd3;
        step();
        ReqA0 = 8'd4; ReqB0 = 8'd5;
        step();
        ReqValid0 = 1'b0;
        #1;
        check("t5_full_rv", {31'd0, RspValid}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("t5_async_rv", {31'd0, RspValid}, 32'd0);
        check("t5_async_mula", {24'd0, MulA}, 32'd0);
        step();
        step();
        Rst_n = 1'b1;
        RspReady = 1'b1;
        repeat (3) step();
        check("t5_no_replay", {31'd0, RspValid}, 32'd0);
        ReqValid0 = 1'b1; ReqValid1 = 1'b1;
        @(negedge Clk);
        check("t5_grant_r0", {31'd0, ReqReady0}, 32'd1);
        check("t5_grant_r1", {31'd0, ReqReady1}, 32'd0);
        step();
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        repeat (3) step();

`ifdef ARB_FIXED_PRIO_EN
        // Test 6: fixed priority keeps requester 0 winning.
        do_reset();
        ReqValid0 = 1'b1; ReqValid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ReqA0 = 8'(i + 1); ReqB0 = 8'd9;
            @(negedge Clk);
            check("t6_grant0", {31'd0, ReqReady0}, 32'd1);
            step();
        end
        ReqValid0 = 1'b0; ReqValid1 = 1'b0;
        repeat (4) step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
